// File: rtl/nios_fprint_mem_arbiter.sv
// Round-robin arbiter letting two Avalon-MM data masters share one single-port RAM.
// Read data is steered back to its requester by a tag pipeline matched to the RAM latency.
module nios_fprint_mem_arbiter #(
    parameter int ADDR_W       = 18,
    parameter int DATA_W       = 32,
    parameter int BE_W         = 4,
    parameter int READ_LATENCY = 1,
    parameter int CNT_W        = 16
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [ADDR_W-1:0] m0_address_i,
    input  logic [BE_W-1:0]   m0_byteenable_i,
    input  logic              m0_read_i,
    input  logic              m0_write_i,
    input  logic [DATA_W-1:0] m0_writedata_i,
    output logic              m0_waitrequest_o,
    output logic [DATA_W-1:0] m0_readdata_o,
    output logic              m0_readdatavalid_o,
    input  logic [ADDR_W-1:0] m1_address_i,
    input  logic [BE_W-1:0]   m1_byteenable_i,
    input  logic              m1_read_i,
    input  logic              m1_write_i,
    input  logic [DATA_W-1:0] m1_writedata_i,
    output logic              m1_waitrequest_o,
    output logic [DATA_W-1:0] m1_readdata_o,
    output logic              m1_readdatavalid_o,
    output logic [ADDR_W-1:0] mem_address_o,
    output logic [BE_W-1:0]   mem_byteenable_o,
    output logic              mem_chipselect_o,
    output logic              mem_write_o,
    output logic [DATA_W-1:0] mem_writedata_o,
    output logic              mem_clken_o,
    input  logic [DATA_W-1:0] mem_readdata_i,
    output logic [CNT_W-1:0]  contention_count_o
);

    logic                    req0, req1, grant0, grant1, anyGrant;
    logic                    selRead, selWrite, grantedRead;
    logic [ADDR_W-1:0]       selAddr;
    logic [BE_W-1:0]         selBe;
    logic [DATA_W-1:0]       selWdata;
    logic                    lastGrant_q, lastGrant_d;
    logic [ADDR_W-1:0]       holdAddr_q, holdAddr_d;
    logic [BE_W-1:0]         holdBe_q, holdBe_d;
    logic [DATA_W-1:0]       holdWdata_q, holdWdata_d;
    logic [READ_LATENCY-1:0] tagValid_q, tagValid_d;
    logic [READ_LATENCY-1:0] tagId_q, tagId_d;
    logic [CNT_W-1:0]        contention_q, contention_d;
    logic                    retValid, retId;

    assign req0 = m0_read_i | m0_write_i;
    assign req1 = m1_read_i | m1_write_i;

    // lastGrant_q = 1 means m1 was served last, so m0 wins the next tie.
    assign grant0   = ~reset_i & req0 & (~req1 | lastGrant_q);
    assign grant1   = ~reset_i & req1 & ~grant0;
    assign anyGrant = grant0 | grant1;

    assign selAddr  = grant1 ? m1_address_i    : m0_address_i;
    assign selBe    = grant1 ? m1_byteenable_i : m0_byteenable_i;
    assign selWdata = grant1 ? m1_writedata_i  : m0_writedata_i;
    assign selRead  = grant1 ? m1_read_i       : m0_read_i;
    assign selWrite = grant1 ? m1_write_i      : m0_write_i;
    assign grantedRead = anyGrant & selRead & ~selWrite;

    assign m0_waitrequest_o = ~(grant0 & req0);
    assign m1_waitrequest_o = ~(grant1 & req1);

    assign mem_address_o    = anyGrant ? selAddr  : holdAddr_q;
    assign mem_byteenable_o = anyGrant ? selBe    : holdBe_q;
    assign mem_writedata_o  = anyGrant ? selWdata : holdWdata_q;
    assign mem_chipselect_o = anyGrant;
    assign mem_write_o      = anyGrant & selWrite;
    assign mem_clken_o      = ~reset_i;

    assign retValid = tagValid_q[READ_LATENCY-1];
    assign retId    = tagId_q[READ_LATENCY-1];

    assign m0_readdatavalid_o = retValid & ~retId;
    assign m1_readdatavalid_o = retValid & retId;
    assign m0_readdata_o      = m0_readdatavalid_o ? mem_readdata_i : '0;
    assign m1_readdata_o      = m1_readdatavalid_o ? mem_readdata_i : '0;
    assign contention_count_o = contention_q;

    always_comb begin
        lastGrant_d  = lastGrant_q;
        holdAddr_d   = holdAddr_q;
        holdBe_d     = holdBe_q;
        holdWdata_d  = holdWdata_q;
        contention_d = contention_q;
        tagValid_d   = '0;
        tagId_d      = '0;
        if (anyGrant) begin
            lastGrant_d = grant1;
            holdAddr_d  = selAddr;
            holdBe_d    = selBe;
            holdWdata_d = selWdata;
        end
        tagValid_d[0] = grantedRead;
        tagId_d[0]    = grant1;
        for (int i = 1; i < READ_LATENCY; i++) begin
            tagValid_d[i] = tagValid_q[i-1];
            tagId_d[i]    = tagId_q[i-1];
        end
        if (req0 && req1 && (contention_q != {CNT_W{1'b1}})) begin
            contention_d = contention_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            lastGrant_q  <= 1'b1;
            holdAddr_q   <= '0;
            holdBe_q     <= '0;
            holdWdata_q  <= '0;
            tagValid_q   <= '0;
            tagId_q      <= '0;
            contention_q <= '0;
        end else begin
            lastGrant_q  <= lastGrant_d;
            holdAddr_q   <= holdAddr_d;
            holdBe_q     <= holdBe_d;
            holdWdata_q  <= holdWdata_d;
            tagValid_q   <= tagValid_d;
            tagId_q      <= tagId_d;
            contention_q <= contention_d;
        end
    end

endmodule
